movimentacao_servo: RTL and testbench

- Sweep sequencer that generates the 2-bit servo position code consumed directly by the servo control stage (`posicao` → PWM width select).
- Steps the position in a ping-pong sweep 00→01→10→11→10→01→00→… with a fixed dwell of PERIODO_PASSO clock cycles per position.
- On stop, returns the servo to 00 one step per dwell before idling.
- Emits a one-cycle `passo` strobe on every position change so downstream measurement logic can sample per position.

---
 rtl/movimentacao_servo.sv | 118 +++++++++++
 tb/tb_movimentacao_servo.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/movimentacao_servo.sv
// Servo sweep sequencer: ping-pong position code 00..11 with fixed dwell per step,
// returning to 00 one step per dwell when switched off.
module movimentacao_servo #(
    parameter int unsigned PERIODO_PASSO = 50000000,
    parameter int unsigned LARGURA_CONT  = $clog2(PERIODO_PASSO)
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ligar,
    input  logic       pausar,
    output logic [1:0] posicao,
    output logic       sentido,
    output logic       passo,
    output logic [1:0] db_estado
);

    typedef enum logic [1:0] {
        StParado  = 2'b00,
        StConta   = 2'b01,
        StRetorno = 2'b10
    } estado_t;

    localparam logic [LARGURA_CONT-1:0] ContFinal = LARGURA_CONT'(PERIODO_PASSO - 1);

    estado_t                 estado_q;
    logic [LARGURA_CONT-1:0] cont_q;
    logic [LARGURA_CONT-1:0] cont_prox;
    logic                    fim;
    logic [1:0]              pos_passo;
    logic                    sent_passo;

    assign db_estado = estado_q;
    assign fim       = !pausar && (cont_q == ContFinal);

    always_comb begin
        cont_prox = cont_q;
        if (fim) begin
            cont_prox = '0;
        end else if (!pausar) begin
            cont_prox = cont_q + 1'b1;
        end
    end

    // Ping-pong step: the end positions reverse direction without repeating.
    always_comb begin
        pos_passo  = posicao;
        sent_passo = sentido;
        if (sentido) begin
            if (posicao == 2'b11) begin
                pos_passo  = 2'b10;
                sent_passo = 1'b0;
            end else begin
                pos_passo = posicao + 2'd1;
            end
        end else begin
            if (posicao == 2'b00) begin
                pos_passo  = 2'b01;
                sent_passo = 1'b1;
            end else begin
                pos_passo = posicao - 2'd1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            estado_q <= StParado;
            cont_q   <= '0;
            posicao  <= 2'b00;
            sentido  <= 1'b1;
            passo    <= 1'b0;
        end else begin
            passo <= 1'b0;
            unique case (estado_q)
                StParado: begin
                    cont_q <= '0;
                    if (ligar) begin
                        estado_q <= StConta;
                    end
                end
                StConta: begin
                    cont_q <= cont_prox;
                    if (fim) begin
                        posicao <= pos_passo;
                        sentido <= sent_passo;
                        passo   <= 1'b1;
                    end
                    // Leaving overrides the step's direction, but the step itself still lands.
                    if (!ligar) begin
                        estado_q <= StRetorno;
                        sentido  <= 1'b0;
                    end
                end
                StRetorno: begin
                    if (posicao == 2'b00) begin
                        estado_q <= StParado;
                        cont_q   <= '0;
                        sentido  <= 1'b1;
                    end else begin
                        cont_q <= cont_prox;
                        if (fim) begin
                            posicao <= posicao - 2'd1;
                            passo   <= 1'b1;
                        end
                        if (ligar) begin
                            estado_q <= StConta;
                        end
                    end
                end
                default: begin
                    estado_q <= StParado;
                    cont_q   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_movimentacao_servo.sv
// Directed bench for movimentacao_servo: expected position changes are queued with their
// cycle stamp and matched against every passo strobe.
module tb_movimentacao_servo;

    localparam int unsigned Periodo = 4;

    logic       clock = 1'b0;
    logic       reset;
    logic       ligar;
    logic       pausar;
    logic [1:0] posicao;
    logic       sentido;
    logic       passo;
    logic [1:0] db_estado;

    typedef struct {
        logic [1:0] pos;
        logic       sent;
        int         cyc;
    } esperado_t;

    esperado_t sb[$];
    int        cyc      = 0;
    int        n_checks = 0;
    int        n_fail   = 0;

    movimentacao_servo #(
        .PERIODO_PASSO(Periodo)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .ligar    (ligar),
        .pausar   (pausar),
        .posicao  (posicao),
        .sentido  (sentido),
        .passo    (passo),
        .db_estado(db_estado)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [1:0] pos, input logic sent, input int c);
        esperado_t e;
        e.pos  = pos;
        e.sent = sent;
        e.cyc  = c;
        sb.push_back(e);
    endtask

    // Advance to the falling edge at which cyc == t.
    task automatic ate(input int t);
        while (cyc < t) @(negedge clock);
    endtask

    always @(negedge clock) begin
        if (passo === 1'b1) begin
            if (sb.size() == 0) begin
                check("passo_inesperado", {30'd0, posicao}, 32'hFFFF_FFFF);
            end else begin
                esperado_t e;
                e = sb.pop_front();
                check("passo_posicao", {30'd0, posicao}, {30'd0, e.pos});
                check("passo_sentido", {31'd0, sentido}, {31'd0, e.sent});
                check("passo_ciclo", cyc, e.cyc);
            end
        end
    end

    initial begin
        int t0;
        logic [1:0] seq_pos[9];
        logic       seq_sent[9];
        seq_pos  = '{2'd1, 2'd2, 2'd3, 2'd2, 2'd1, 2'd0, 2'd1, 2'd2, 2'd3};
        seq_sent = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

        reset  = 1'b0;
        ligar  = 1'b0;
        pausar = 1'b0;
        repeat (2) @(negedge clock);
        check("reset_posicao", {30'd0, posicao}, 32'd0);
        check("reset_sentido", {31'd0, sentido}, 32'd1);
        check("reset_passo", {31'd0, passo}, 32'd0);
        check("reset_estado", {30'd0, db_estado}, 32'd0);
        reset = 1'b1;
        @(negedge clock);
        check("parado_ocioso", {30'd0, db_estado}, 32'd0);

        // Full sweep up to the second visit of 11, then switch off and return.
        t0    = cyc;
        ligar = 1'b1;
        for (int i = 0; i < 9; i++) push(seq_pos[i], seq_sent[i], t0 + 1 + Periodo * (i + 1));
        ate(t0 + 2);
        check("conta_estado", {30'd0, db_estado}, 32'd1);
        check("conta_sentido", {31'd0, sentido}, 32'd1);
        ate(t0 + 37);
        check("topo_posicao", {30'd0, posicao}, 32'd3);
        ligar = 1'b0;
        push(2'd2, 1'b0, t0 + 41);
        push(2'd1, 1'b0, t0 + 45);
        push(2'd0, 1'b0, t0 + 49);
        ate(t0 + 38);
        check("retorno_estado", {30'd0, db_estado}, 32'd2);
        check("retorno_sentido", {31'd0, sentido}, 32'd0);
        check("retorno_posicao", {30'd0, posicao}, 32'd3);
        ate(t0 + 50);
        check("fim_estado", {30'd0, db_estado}, 32'd0);
        check("fim_posicao", {30'd0, posicao}, 32'd0);
        check("fim_sentido", {31'd0, sentido}, 32'd1);
        ate(t0 + 56);
        check("fila_vazia_1", sb.size(), 32'd0);

        // Seven-cycle pause one cycle into the second dwell.
        t0    = cyc;
        ligar = 1'b1;
        push(2'd1, 1'b1, t0 + 5);
        push(2'd2, 1'b1, t0 + 16);
        ate(t0 + 6);
        pausar = 1'b1;
        ate(t0 + 10);
        check("pausa_posicao", {30'd0, posicao}, 32'd1);
        check("pausa_estado", {30'd0, db_estado}, 32'd1);
        ate(t0 + 13);
        pausar = 1'b0;
        ate(t0 + 15);
        check("pausa_atraso", {30'd0, posicao}, 32'd1);
        ate(t0 + 16);
        check("pausa_passo", {30'd0, posicao}, 32'd2);

        // Synchronous reset mid-dwell at posicao 10.
        ate(t0 + 18);
        reset = 1'b0;
        ligar = 1'b0;
        #2;
        check("reset_sincrono_pos", {30'd0, posicao}, 32'd2);
        check("reset_sincrono_est", {30'd0, db_estado}, 32'd1);
        ate(t0 + 19);
        check("reset_meio_posicao", {30'd0, posicao}, 32'd0);
        check("reset_meio_sentido", {31'd0, sentido}, 32'd1);
        check("reset_meio_passo", {31'd0, passo}, 32'd0);
        check("reset_meio_estado", {30'd0, db_estado}, 32'd0);
        reset = 1'b1;
        ate(t0 + 25);
        check("fila_vazia_2", sb.size(), 32'd0);
        check("reset_parado", {30'd0, posicao}, 32'd0);

        // Switch-off coinciding with the terminal count at posicao 01.
        t0    = cyc;
        ligar = 1'b1;
        push(2'd1, 1'b1, t0 + 5);
        ate(t0 + 8);
        ligar = 1'b0;
        push(2'd2, 1'b0, t0 + 9);
        push(2'd1, 1'b0, t0 + 13);
        push(2'd0, 1'b0, t0 + 17);
        ate(t0 + 10);
        check("coincide_estado", {30'd0, db_estado}, 32'd2);
        check("coincide_sentido", {31'd0, sentido}, 32'd0);
        ate(t0 + 18);
        check("coincide_fim_est", {30'd0, db_estado}, 32'd0);
        check("coincide_fim_sent", {31'd0, sentido}, 32'd1);
        ate(t0 + 22);
        check("fila_vazia_3", sb.size(), 32'd0);

        // Resume from RETORNO at posicao 10: sweep continues descending, counter kept.
        t0    = cyc;
        ligar = 1'b1;
        push(2'd1, 1'b1, t0 + 5);
        push(2'd2, 1'b1, t0 + 9);
        push(2'd3, 1'b1, t0 + 13);
        ate(t0 + 13);
        ligar = 1'b0;
        push(2'd2, 1'b0, t0 + 17);
        ate(t0 + 19);
        check("retoma_pre_estado", {30'd0, db_estado}, 32'd2);
        ligar = 1'b1;
        push(2'd1, 1'b0, t0 + 21);
        push(2'd0, 1'b0, t0 + 25);
        push(2'd1, 1'b1, t0 + 29);
        ate(t0 + 20);
        check("retoma_estado", {30'd0, db_estado}, 32'd1);
        check("retoma_sentido", {31'd0, sentido}, 32'd0);
        ate(t0 + 29);
        ligar = 1'b0;
        push(2'd0, 1'b0, t0 + 33);
        ate(t0 + 34);
        check("final_estado", {30'd0, db_estado}, 32'd0);
        check("final_posicao", {30'd0, posicao}, 32'd0);
        check("final_sentido", {31'd0, sentido}, 32'd1);
        ate(t0 + 40);
        check("fila_vazia_4", sb.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
